seg_display_driver: RTL
=======================

# seg_display_driver

Multiplexed driver for the Alchitry IO board's 4-digit seven-segment display (io_seg / io_sel); the output-side counterpart to the board's DIP/button input conditioning. It accepts a display word (hex nibbles, decimal points, digit enables) over a valid/ready handshake and double-buffers it. It scans the digits with a blanking gap at every digit change to prevent ghosting, and drives active-low segment and select lines from registers. It sits in top between user logic and the io_seg/io_sel pins.

## Interface
- DIGITS, 4, number of digits scanned (1..8)
- DIGIT_CYCLES, 100000, clocks per digit slot (1 ms at 100 MHz); must be >= 2
- BLANK_CYCLES, 1000, all-off clocks at the start of each slot; must be < DIGIT_CYCLES

- clk  input  1  system clock (100 MHz)
- rst_n  input  1  asynchronous, active-low reset
- in_value  input  4*DIGITS  hex nibble per digit; nibble 0 = digit 0 (rightmost)
- in_dp  input  DIGITS  decimal point per digit, 1 = lit
- in_en  input  DIGITS  digit enable; 0 = digit dark for its whole slot
- in_valid  input  1  display word offered
- in_ready  output  1  pending buffer empty; word accepted when in_valid & in_ready
- frame_start  output  1  one-cycle pulse at the start of each digit-0 slot
- io_seg  output  8  active-low segments; bit0..6 = a..g, bit7 = dp
- io_sel  output  DIGITS  active-low digit select; bit d = digit d

## Operation
- Two buffers: pending (value/dp/en plus full flag) and active (value/dp/en).
- in_ready = !pending_full. An accept loads pending and sets pending_full.
- Frame boundary: slot_cnt == 0 and digit == 0.
  - If pending_full at a boundary, copy pending to active and clear pending_full in that cycle.
  - Because in_ready is 0 whenever pending_full is 1, an accept and a transfer never coincide.
  - A word accepted on a boundary cycle with pending empty waits for the next boundary.
- Scan counters:
  - slot_cnt counts 0..DIGIT_CYCLES-1.
  - digit counts 0..DIGITS-1 and advances when slot_cnt wraps; digit wraps DIGITS-1 -> 0.
- Output register:
  - Blank (io_sel all ones, io_seg 8'hFF) when slot_cnt < BLANK_CYCLES or active en[digit] == 0.
  - Otherwise io_sel = ~(1 << digit) and io_seg = ~{dp[digit], hex7(nibble[digit])}.
- hex7 (active-high g..a), 0..F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- At most one io_sel bit is ever low, and there is never an overlap between digits.
- Counter widths are sized by $clog2 of DIGIT_CYCLES and DIGITS. No counter may overflow past its terminal value.

## Timing
- Reset state (asynchronous, immediate):
  - slot_cnt = 0, digit = 0, pending_full = 0.
  - active value/dp/en = 0, so the display is dark until the first transfer.
  - io_seg = 8'hFF, io_sel = all ones, frame_start = 0, in_ready = 1.
- First clock edge after rst_n rises: counters sit at the boundary state, and frame_start is asserted after that edge.
- io_seg, io_sel and frame_start are registered and lag the counter state by exactly one cycle.
- frame_start period = DIGITS*DIGIT_CYCLES cycles; each pulse is 1 cycle wide.
- Each digit slot: first BLANK_CYCLES cycles all-off, then DIGIT_CYCLES-BLANK_CYCLES cycles driven.
- Accept-to-display latency: the word becomes active at the first boundary after the accept. Its digit-0 segments appear BLANK_CYCLES+1 cycles after that boundary.
- in_ready falls the cycle after an accept and rises the cycle after the transfer.
- Reset asserted mid-frame: outputs blank immediately, pending is discarded, and scanning restarts from digit 0 after release.
- Parameters permit DIGITS = 1; in that case every slot is a frame boundary.

## Test plan
All scenarios use DIGITS=4, DIGIT_CYCLES=8, BLANK_CYCLES=2.
- Reset, then hold rst_n low: io_seg=8'hFF, io_sel=4'hF, in_ready=1, frame_start=0. After release, frame_start pulses every 32 cycles.
- Accept in_value=16'h1234, in_en=4'hF, in_dp=0:
  - From the next boundary, slots show io_sel=E/D/B/7 with io_seg=99/B0/A4/F9.
  - Each slot starts with 2 blank cycles.
- Backpressure:
  - Word A accepted; in_ready stays 0 while word B is held valid.
  - A transfers at the boundary, then B is accepted the cycle after in_ready rises.
  - A is displayed for the full frame; B is displayed from the following frame.
- Masking and dp with in_value=16'hABCD, in_en=4'b0101, in_dp=4'b0001:
  - digit0 io_seg=~{1,5E}=8'h21.
  - digit1 and digit3 slots are fully blank.
  - digit2 io_seg=~7C=8'h83.
- Reset mid-scan: assert rst_n during a digit2 driven cycle with pending full.
  - Outputs go to FF/F immediately and active is cleared.
  - After release, the display stays dark and in_ready=1.
- Continuous checker: io_sel never has more than one bit low, and no lit cycle falls inside a blank window.

Source files
------------

// File: rtl/seg_display_driver.sv
// Multiplexed driver for a multi-digit seven-segment display with double-buffered input word.
// Scans digits with an all-off gap at each slot start; segment and select lines are active-low.
module seg_display_driver #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   in_value,
  input  logic [DIGITS-1:0]     in_dp,
  input  logic [DIGITS-1:0]     in_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  frame_start,
  output logic [7:0]            io_seg,
  output logic [DIGITS-1:0]     io_sel
);

  localparam int unsigned SlotW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int unsigned DigW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SlotW-1:0] SlotLast  = SlotW'(DIGIT_CYCLES - 1);
  localparam logic [DigW-1:0]  DigLast   = DigW'(DIGITS - 1);
  localparam logic [SlotW-1:0] BlankLast = SlotW'(BLANK_CYCLES);

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] segs;
    case (nib)
      4'h0:    segs = 7'h3F;
      4'h1:    segs = 7'h06;
      4'h2:    segs = 7'h5B;
      4'h3:    segs = 7'h4F;
      4'h4:    segs = 7'h66;
      4'h5:    segs = 7'h6D;
      4'h6:    segs = 7'h7D;
      4'h7:    segs = 7'h07;
      4'h8:    segs = 7'h7F;
      4'h9:    segs = 7'h6F;
      4'hA:    segs = 7'h77;
      4'hB:    segs = 7'h7C;
      4'hC:    segs = 7'h39;
      4'hD:    segs = 7'h5E;
      4'hE:    segs = 7'h79;
      default: segs = 7'h71;
    endcase
    return segs;
  endfunction

  // Scan counters
  logic [SlotW-1:0] slot_q, slot_d;
  logic [DigW-1:0]  digit_q, digit_d;

  // Pending and active buffers
  logic [4*DIGITS-1:0] pend_value_q, pend_value_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]   pend_en_q, pend_en_d;
  logic                pend_full_q, pend_full_d;
  logic [4*DIGITS-1:0] act_value_q, act_value_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   act_en_q, act_en_d;

  // Output registers
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic              frame_start_q, frame_start_d;

  logic boundary;
  logic accept;
  logic transfer;
  logic in_blank;
  logic [3:0] nibble;

  assign boundary = (slot_q == '0) && (digit_q == '0);
  assign in_ready = !pend_full_q;
  assign accept   = in_valid && in_ready;
  // Accept and transfer are exclusive: transfer needs pending full, accept needs it empty.
  assign transfer = boundary && pend_full_q;

  always_comb begin
    slot_d  = slot_q + 1'b1;
    digit_d = digit_q;
    if (slot_q == SlotLast) begin
      slot_d  = '0;
      digit_d = (digit_q == DigLast) ? '0 : digit_q + 1'b1;
    end
  end

  always_comb begin
    pend_value_d = pend_value_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    pend_full_d  = pend_full_q;
    act_value_d  = act_value_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;
    if (transfer) begin
      act_value_d = pend_value_q;
      act_dp_d    = pend_dp_q;
      act_en_d    = pend_en_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_value_d = in_value;
      pend_dp_d    = in_dp;
      pend_en_d    = in_en;
      pend_full_d  = 1'b1;
    end
  end

  // Outputs use the post-transfer word so a zero blank window still shows the new word.
  assign in_blank = (slot_q < BlankLast);
  assign nibble   = act_value_d[{digit_q, 2'b00} +: 4];

  always_comb begin
    seg_d         = 8'hFF;
    sel_d         = '1;
    frame_start_d = boundary;
    if (!in_blank && act_en_d[digit_q]) begin
      sel_d[digit_q] = 1'b0;
      seg_d          = ~{act_dp_d[digit_q], hex7(nibble)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q        <= '0;
      digit_q       <= '0;
      pend_value_q  <= '0;
      pend_dp_q     <= '0;
      pend_en_q     <= '0;
      pend_full_q   <= 1'b0;
      act_value_q   <= '0;
      act_dp_q      <= '0;
      act_en_q      <= '0;
      seg_q         <= 8'hFF;
      sel_q         <= '1;
      frame_start_q <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      digit_q       <= digit_d;
      pend_value_q  <= pend_value_d;
      pend_dp_q     <= pend_dp_d;
      pend_en_q     <= pend_en_d;
      pend_full_q   <= pend_full_d;
      act_value_q   <= act_value_d;
      act_dp_q      <= act_dp_d;
      act_en_q      <= act_en_d;
      seg_q         <= seg_d;
      sel_q         <= sel_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign io_seg      = seg_q;
  assign io_sel      = sel_q;
  assign frame_start = frame_start_q;

endmodule
